// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO behind a UART receiver with a capture handshake and sticky error flags
// Ports: clk, clr (sync active-high reset); rdrf/rx_data/FE from the receiver, rdrf_clr acknowledge back;
// rd_en read request, dout/dout_fe/dout_valid registered read port; empty/full/count occupancy;
// overrun/fe_err sticky flags cleared by err_clr.
// Option RX_FIFO_FE_DROP_EN: discard bytes received with FE=1 (dout_fe then always 0).
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rdrf,
  input  logic [7:0]        rx_data,
  input  logic              FE,
  output logic              rdrf_clr,
  input  logic              rd_en,
  output logic [7:0]        dout,
  output logic              dout_fe,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              fe_err,
  input  logic              err_clr
);
`ifdef RX_FIFO_FE_DROP_EN
  localparam logic FE_KEEP = 1'b0;
`else
  localparam logic FE_KEEP = 1'b1;
`endif
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t state;
  logic [8:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic cap, wr, rd;
  logic [ADDR_W:0] count_nxt;
  always_comb begin
    cap = state == IDLE && rdrf;
    wr = cap && !full && (FE_KEEP || !FE);
    rd = rd_en && !empty;
    count_nxt = count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
  end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {FE & FE_KEEP, rx_data};
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      rdrf_clr <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      dout <= '0;
      dout_fe <= 1'b0;
      dout_valid <= 1'b0;
      overrun <= 1'b0;
      fe_err <= 1'b0;
    end else begin
      state <= state == IDLE ? (rdrf ? ACK : IDLE) : state == ACK ? WAIT : (rdrf ? WAIT : IDLE);
      rdrf_clr <= cap;
      wptr <= wptr + ADDR_W'(wr);
      rptr <= rptr + ADDR_W'(rd);
      count <= count_nxt;
      empty <= count_nxt == '0;
      full <= count_nxt == FULL_CNT;
      dout_valid <= rd;
      if (rd) {dout_fe, dout} <= mem[rptr];
      overrun <= (cap && full) || (overrun && !err_clr);
      fe_err <= (cap && FE) || (fe_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scoreboard bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
`ifdef RX_FIFO_FE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic rdrf = 1'b0;
  logic [7:0] rx_data = '0;
  logic fe = 1'b0;
  logic rdrf_clr;
  logic rd_en = 1'b0;
  logic [7:0] dout;
  logic dout_fe;
  logic dout_valid;
  logic empty;
  logic full;
  logic [4:0] count;
  logic overrun;
  logic fe_err;
  logic err_clr = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [8:0] fifo [$];
  logic [8:0] exp_q [$];
  bit ov_m = 1'b0;
  bit fe_m = 1'b0;
  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .rdrf(rdrf), .rx_data(rx_data), .FE(fe),
    .rdrf_clr(rdrf_clr), .rd_en(rd_en), .dout(dout), .dout_fe(dout_fe),
    .dout_valid(dout_valid), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .fe_err(fe_err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rdrf_clr) pulses++;
  always @(negedge clk)
    if (dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read actual %0h required no dout_valid", {dout_fe, dout});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({dout_fe, dout} !== e) begin
          errors++;
          $display("FAIL read_data actual %0h required %0h", {dout_fe, dout}, e);
        end
      end
    end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic chk_state(input string name);
    chk({name, "_count"}, int'(count), fifo.size());
    chk({name, "_empty"}, int'(empty), int'(fifo.size() == 0));
    chk({name, "_full"}, int'(full), int'(fifo.size() == DEPTH));
    chk({name, "_overrun"}, int'(overrun), int'(ov_m));
    chk({name, "_fe_err"}, int'(fe_err), int'(fe_m));
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_rdrf_clr"}, int'(rdrf_clr), 0);
    chk({name, "_dout"}, int'({dout_fe, dout}), 0);
    chk({name, "_dout_valid"}, int'(dout_valid), 0);
    chk_state(name);
  endtask
  task automatic model_cap(input logic [7:0] b, input logic f);
    if (f) fe_m = 1'b1;
    if (fifo.size() == DEPTH) ov_m = 1'b1;
    else if (!(DROP && f)) fifo.push_back({f, b});
  endtask
  task automatic send(input logic [7:0] b, input logic f, input int hold);
    int p0;
    int n;
    p0 = pulses;
    rdrf = 1'b1;
    rx_data = b;
    fe = f;
    model_cap(b, f);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdrf_clr && n < 10);
    if (!rdrf_clr) begin
      errors++;
      $display("FAIL ack_timeout actual rdrf_clr=0 required 1 within 10 cycles");
    end
    repeat (hold) @(negedge clk);
    rdrf = 1'b0;
    rx_data = 8'($urandom);
    fe = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack_pulses", pulses - p0, 1);
  endtask
  task automatic rd1();
    rd_en = 1'b1;
    if (fifo.size() != 0) exp_q.push_back(fifo.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic pulse_err_clr();
    err_clr = 1'b1;
    ov_m = 1'b0;
    fe_m = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk_reset("reset");
    send(8'h55, 1'b0, 2);
    chk_state("one_byte");
    rd1();
    @(negedge clk);
    chk_state("one_read");
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 2);
    chk_state("filled");
    send(8'hAA, 1'b0, 2);
    chk_state("overrun");
    for (int i = 0; i < DEPTH; i++) rd1();
    @(negedge clk);
    chk_state("drained");
    pulse_err_clr();
    chk_state("err_clr_ov");
    send(8'h77, 1'b0, 10);
    chk_state("long_rdrf");
    rd1();
    send(8'h3C, 1'b1, 2);
    chk_state("fe_byte");
    rd1();
    @(negedge clk);
    pulse_err_clr();
    chk_state("err_clr_fe");
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1);
    chk_state("five");
    rdrf = 1'b1;
    rx_data = 8'hC3;
    fe = 1'b0;
    rd1();
    model_cap(8'hC3, 1'b0);
    chk_state("rd_wr_same");
    chk("rd_wr_ack", int'(rdrf_clr), 1);
    repeat (2) @(negedge clk);
    rdrf = 1'b0;
    repeat (2) @(negedge clk);
    while (fifo.size() != 0) rd1();
    @(negedge clk);
    rd1();
    chk("empty_rd_valid", int'(dout_valid), 0);
    chk_state("empty_rd");
    for (int i = 0; i < 120; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3));
      else if (op < 9) rd1();
      else pulse_err_clr();
      @(negedge clk);
      chk_state("rand");
    end
    while (fifo.size() < 3) send(8'($urandom), 1'b0, 1);
    while (fifo.size() > 3) rd1();
    @(negedge clk);
    chk_state("pre_clr");
    rdrf = 1'b1;
    rx_data = 8'h99;
    @(negedge clk);
    chk("pre_clr_ack", int'(rdrf_clr), 1);
    clr = 1'b1;
    rdrf = 1'b0;
    fifo.delete();
    exp_q.delete();
    ov_m = 1'b0;
    fe_m = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk_reset("mid_clr");
    repeat (2) @(negedge clk);
    chk_reset("post_clr");
    chk("pending_reads", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. Watches the receiver's ready flag, captures each received byte with its framing-error bit, acknowledges the receiver with a one-cycle clear pulse, and stores the entry in a circular FIFO. Read-side logic or the host drains bytes through a registered read port. Sticky overrun and framing-error flags report bytes that were dropped or damaged.

## Interface
Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 2 to 256
- ADDR_W, 4, log2(DEPTH); must match DEPTH

Ports:
- clk  in  1  system clock; all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- rdrf  in  1  receiver data-ready flag
- rx_data  in  8  received byte; valid while rdrf=1
- FE  in  1  receiver framing-error flag; valid while rdrf=1
- rdrf_clr  out  1  one-cycle acknowledge pulse to the receiver
- rd_en  in  1  read request; honoured only when empty=0
- dout  out  8  read data; holds its value until the next accepted read
- dout_fe  out  1  framing-error bit of the entry on dout
- dout_valid  out  1  one-cycle pulse, asserted the cycle after an accepted read
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky; a byte was dropped because the FIFO was full
- fe_err  out  1  sticky; a byte was captured with FE=1
- err_clr  in  1  clears overrun and fe_err

## Operation
- Storage: DEPTH x 9-bit entries {FE, rx_data}. Write and read pointers are ADDR_W bits and wrap modulo DEPTH. count is updated every cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- Capture FSM, 3 states:
  - IDLE: if rdrf=1, capture rx_data and FE. Write the entry if not full, otherwise set overrun. Set rdrf_clr<=1 and go to ACK.
  - ACK: rdrf_clr<=0, go to WAIT.
  - WAIT: stay until rdrf=0, then go to IDLE. This prevents double capture of one byte.
- Full check: full is evaluated from the registered state before the edge. If a write arrives when full, the byte is dropped, even if a read is accepted in the same cycle.
- Read: if rd_en=1 and empty=0, then on the next edge dout/dout_fe take the entry at the read pointer, the pointer increments, and dout_valid=1 for one cycle. rd_en while empty is ignored with no state change.
- Simultaneous write and read on a non-empty, non-full FIFO: both occur and count is unchanged. Simultaneous write and read on an empty FIFO: the read is ignored and the write proceeds.
- Sticky flags: err_clr=1 clears overrun and fe_err. A set event in the same cycle wins over err_clr.

## Timing
- Reset (clr=1 at an edge): state IDLE, pointers 0, count=0, empty=1, full=0, rdrf_clr=0, dout=0, dout_fe=0, dout_valid=0, overrun=0, fe_err=0. FIFO contents are discarded. A capture or read in progress is abandoned.
- Capture latency: rdrf sampled high at edge N produces:
  - entry written and count incremented at edge N
  - rdrf_clr high during cycle N+1
  - capture FSM back in IDLE no earlier than edge N+2
- Maximum capture rate is one byte per 3 cycles, far above the UART byte rate.
- Read latency: 1 cycle from rd_en to dout/dout_valid.
- empty, full and count are registered and reflect all operations completed at the previous edge.

## Configuration
- RX_FIFO_FE_DROP_EN defined: bytes captured with FE=1 are not written. They still set fe_err and still produce the rdrf_clr acknowledge. dout_fe is tied to 0.
- RX_FIFO_FE_DROP_EN undefined: bytes with FE=1 are stored, and the flag is presented on dout_fe when that entry is read.

## Test plan
- Reset, then rdrf=1 with rx_data=0x55 and FE=0, dropped 2 cycles after rdrf_clr -> exactly one rdrf_clr pulse, count=1, empty=0. Then rd_en -> dout=0x55, dout_valid pulse, empty=1.
- Write DEPTH=16 bytes 0x00..0x0F, then one more byte 0xAA -> full=1, count=16, overrun=1, 0xAA absent. Drain 16 reads -> 0x00..0x0F in order with pointer wrap.
- Hold rdrf=1 for 10 cycles for one byte -> one write and one rdrf_clr pulse only.
- Capture 0x3C with FE=1 -> fe_err=1. Macro undefined: read gives dout=0x3C, dout_fe=1. Macro defined: count stays 0. Then err_clr -> fe_err=0.
- FIFO at count=5, rd_en and capture in the same cycle -> count stays 5. rd_en on an empty FIFO -> no dout_valid, count stays 0.
- clr asserted mid-capture (during ACK) with count=3 -> next cycle count=0, rdrf_clr=0, all outputs at reset values.
